// File: rtl/mc_pkg.sv
// mc_pkg: state encoding, opcode/funct constants and datapath select codes for the multicycle controller
package mc_pkg;
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  function automatic logic is_wait_state(input logic [3:0] s);
    return s == S_FETCH || s == S_MEMRD || s == S_MEMWR;
  endfunction
endpackage

// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if: instruction/status inputs and datapath control outputs of the main controller
interface mc_control_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_en;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_src;
  logic       illegal;
  logic       mem_timeout;
  logic [3:0] state;
  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, illegal, mem_timeout, state
  );
  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, illegal, mem_timeout, state
  );
endinterface

// File: rtl/mc_control_fsm_alu_decoder.sv
// alu_decoder: R-type funct field to ALU op code plus a legality flag
module alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       funct_ok
);
  always_comb begin
    alu_op = funct == F_SUB ? ALU_SUB :
             funct == F_AND ? ALU_AND :
             funct == F_OR  ? ALU_OR  :
             funct == F_SLT ? ALU_SLT : ALU_ADD;
    funct_ok = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
  end
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS main controller with memory wait watchdog
// Define MC_CTRL_BNE_EN to decode bne (opcode 000101) as an inverted-zero branch.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4
) (
  input logic              clk,
  input logic              rst_n,
  mc_control_fsm_if.master bus
);
  logic [3:0]        state_q;
  logic [3:0]        state_n;
  logic [WAIT_W-1:0] cnt;
  logic              timeout;
  logic              op_ok;
  logic              funct_ok;
  logic              br_take;
  logic [2:0]        dec_op;
  alu_decoder u_dec (
    .funct   (bus.funct),
    .alu_op  (dec_op),
    .funct_ok(funct_ok)
  );
`ifdef MC_CTRL_BNE_EN
  assign op_ok   = bus.opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
  assign br_take = bus.opcode == OP_BNE ? ~bus.zero : bus.zero;
`else
  assign op_ok   = bus.opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  assign br_take = bus.zero;
`endif
  // a ready on the expiry cycle completes normally, so timeout requires mem_ready low
  assign timeout = is_wait_state(state_q) && !bus.mem_ready && cnt == WAIT_W'(WAIT_MAX - 1);
  always_comb begin
    state_n = S_FETCH;
    case (state_q)
      S_FETCH:  state_n = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_n = !op_ok ? S_FETCH :
                          bus.opcode == OP_RTYPE ? S_EXEC :
                          (bus.opcode == OP_LW || bus.opcode == OP_SW) ? S_MEMADR :
                          bus.opcode == OP_ADDI ? S_ADDIEX :
                          bus.opcode == OP_J ? S_JUMP : S_BRANCH;
      S_MEMADR: state_n = bus.opcode == OP_SW ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_n = bus.mem_ready ? S_MEMWB : timeout ? S_FETCH : S_MEMRD;
      S_MEMWR:  state_n = (bus.mem_ready || timeout) ? S_FETCH : S_MEMWR;
      S_EXEC:   state_n = funct_ok ? S_ALUWB : S_FETCH;
      S_ADDIEX: state_n = S_ADDIWB;
      default:  state_n = S_FETCH;
    endcase
  end
  // only wait states can stay put; any transition or expiry restarts the watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt     <= '0;
    end else begin
      state_q <= state_n;
      cnt     <= (state_n == state_q && !timeout) ? cnt + WAIT_W'(1) : '0;
    end
  end
  // enables are gated by rst_n so a held reset suppresses the FETCH ready path too
  assign bus.ir_write    = rst_n && state_q == S_FETCH && bus.mem_ready;
  assign bus.pc_en       = rst_n && ((state_q == S_FETCH && bus.mem_ready) ||
                                     (state_q == S_BRANCH && br_take) || state_q == S_JUMP);
  assign bus.iord        = state_q == S_MEMRD || state_q == S_MEMWR;
  assign bus.mem_write   = rst_n && state_q == S_MEMWR && !timeout;
  assign bus.reg_dst     = state_q == S_ALUWB;
  assign bus.mem_to_reg  = state_q == S_MEMWB;
  assign bus.reg_write   = rst_n && (state_q == S_MEMWB || state_q == S_ALUWB || state_q == S_ADDIWB);
  assign bus.alu_src_a   = state_q == S_MEMADR || state_q == S_EXEC || state_q == S_BRANCH || state_q == S_ADDIEX;
  assign bus.alu_src_b   = state_q == S_FETCH ? SRCB_FOUR :
                           state_q == S_DECODE ? SRCB_IMM_SH :
                           (state_q == S_MEMADR || state_q == S_ADDIEX) ? SRCB_IMM : SRCB_B;
  assign bus.alu_op      = state_q == S_EXEC ? dec_op : state_q == S_BRANCH ? ALU_SUB : ALU_ADD;
  assign bus.pc_src      = state_q == S_BRANCH ? PC_ALUOUT : state_q == S_JUMP ? PC_JUMP : PC_ALU;
  assign bus.illegal     = rst_n && ((state_q == S_DECODE && !op_ok) || (state_q == S_EXEC && !funct_ok));
  assign bus.mem_timeout = rst_n && timeout;
  assign bus.state       = state_q;
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: per-instruction expected control traces checked cycle by cycle against the controller
module tb_mc_control_fsm;
  import mc_pkg::*;
  localparam int WAIT_MAX = 15;
  localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010, A_SUB = 3'b110, A_SLT = 3'b111;
  localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011, O_BEQ = 6'b000100;
  localparam logic [5:0] O_BNE = 6'b000101, O_ADDI = 6'b001000, O_J = 6'b000010;
  typedef struct packed {
    logic        mr;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic [17:0] v;
  } step_t;
  step_t tq[$];
  int tests = 0;
  int fails = 0;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] cur_op;
  logic [5:0] cur_fn;
  logic cur_z;
  logic [17:0] obs_v;
  mc_control_fsm_if bus ();
  mc_control_fsm #(.WAIT_MAX(WAIT_MAX), .WAIT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign obs_v = {bus.pc_en, bus.iord, bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg,
                  bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_src,
                  bus.illegal, bus.mem_timeout};
  function automatic logic [17:0] ctl(input logic pe, io, mw, iw, rd, m2r, rw, sa,
                                      input logic [1:0] sb, input logic [2:0] aop,
                                      input logic [1:0] ps, input logic il, to);
    return {pe, io, mw, iw, rd, m2r, rw, sa, sb, aop, ps, il, to};
  endfunction
  function automatic void push(input logic mr, input logic [17:0] v);
    step_t s;
    s.mr = mr; s.op = cur_op; s.fn = cur_fn; s.z = cur_z; s.v = v;
    tq.push_back(s);
  endfunction
  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction
  // expected cycle sequence for one instruction, given fetch and memory wait counts
  function automatic void add_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                    input int fw, input int mw);
    int k = 0;
    logic legal, ok, taken;
    logic [2:0] aop;
    cur_op = op; cur_fn = fn; cur_z = z;
    for (int i = 0; i < fw; i++) begin
      push(1'b0, ctl(0,0,0,0,0,0,0,0,2'b01,A_ADD,2'b00,0,k == WAIT_MAX-1));
      k = (k == WAIT_MAX-1) ? 0 : k + 1;
    end
    push(1'b1, ctl(1,0,0,1,0,0,0,0,2'b01,A_ADD,2'b00,0,0));
`ifdef MC_CTRL_BNE_EN
    legal = op inside {O_R, O_LW, O_SW, O_BEQ, O_BNE, O_ADDI, O_J};
`else
    legal = op inside {O_R, O_LW, O_SW, O_BEQ, O_ADDI, O_J};
`endif
    push(rnd(), ctl(0,0,0,0,0,0,0,0,2'b11,A_ADD,2'b00,!legal,0));
    if (!legal) return;
    case (op)
      O_R: begin
        ok = fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        aop = fn == 6'b100010 ? A_SUB : fn == 6'b100100 ? A_AND : fn == 6'b100101 ? A_OR :
              fn == 6'b101010 ? A_SLT : A_ADD;
        push(rnd(), ctl(0,0,0,0,0,0,0,1,2'b00,aop,2'b00,!ok,0));
        if (ok) push(rnd(), ctl(0,0,0,0,1,0,1,0,2'b00,A_ADD,2'b00,0,0));
      end
      O_LW, O_SW: begin
        push(rnd(), ctl(0,0,0,0,0,0,0,1,2'b10,A_ADD,2'b00,0,0));
        for (int i = 0; i <= mw; i++) begin
          if (i == mw) push(1'b1, ctl(0,1,op == O_SW,0,0,0,0,0,2'b00,A_ADD,2'b00,0,0));
          else if (i == WAIT_MAX-1) begin
            push(1'b0, ctl(0,1,0,0,0,0,0,0,2'b00,A_ADD,2'b00,0,1));
            return;
          end else push(1'b0, ctl(0,1,op == O_SW,0,0,0,0,0,2'b00,A_ADD,2'b00,0,0));
        end
        if (op == O_LW) push(rnd(), ctl(0,0,0,0,0,1,1,0,2'b00,A_ADD,2'b00,0,0));
      end
      O_ADDI: begin
        push(rnd(), ctl(0,0,0,0,0,0,0,1,2'b10,A_ADD,2'b00,0,0));
        push(rnd(), ctl(0,0,0,0,0,0,1,0,2'b00,A_ADD,2'b00,0,0));
      end
      O_J: push(rnd(), ctl(1,0,0,0,0,0,0,0,2'b00,A_ADD,2'b10,0,0));
      default: begin
        taken = (op == O_BNE) ? !z : z;
        push(rnd(), ctl(taken,0,0,0,0,0,0,1,2'b00,A_SUB,2'b01,0,0));
      end
    endcase
  endfunction
  task automatic test_reset();
    rst_n = 1'b0; bus.mem_ready = 1'b1; bus.opcode = O_LW; bus.funct = 6'd0; bus.zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({bus.ir_write, bus.pc_en, bus.mem_write, bus.reg_write, bus.illegal, bus.mem_timeout} !== 6'b0) begin
      fails++; $display("FAIL reset_enables: got %b expected 000000",
        {bus.ir_write, bus.pc_en, bus.mem_write, bus.reg_write, bus.illegal, bus.mem_timeout});
    end
    tests++;
    if (bus.state !== S_FETCH) begin fails++; $display("FAIL reset_state: got %0d expected %0d", bus.state, S_FETCH); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({bus.ir_write, bus.pc_en} !== 2'b11) begin fails++; $display("FAIL release_fetch: got %b expected 11", {bus.ir_write, bus.pc_en}); end
    @(posedge clk); #1 bus.mem_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    tests++;
    if (bus.state !== S_MEMRD) begin fails++; $display("FAIL pre_abort_state: got %0d expected %0d", bus.state, S_MEMRD); end
    bus.mem_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.state !== S_FETCH || {bus.ir_write, bus.pc_en, bus.reg_write, bus.mem_write} !== 4'b0) begin
      fails++; $display("FAIL midaccess_reset: state %0d en %b expected %0d 0000", bus.state,
        {bus.ir_write, bus.pc_en, bus.reg_write, bus.mem_write}, S_FETCH);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask
  task automatic test_rtype();
    logic [5:0] fl[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    tq.delete();
    add_instr(O_R, 6'b100010, 1'b0, 0, 0);
    for (int n = 0; n < 5; n++) add_instr(O_R, fl[$urandom_range(0, 4)], rnd(), $urandom_range(0, 3), 0);
    foreach (tq[i]) begin
      {bus.mem_ready, bus.opcode, bus.funct, bus.zero} = {tq[i].mr, tq[i].op, tq[i].fn, tq[i].z};
      @(negedge clk); tests++;
      if (obs_v !== tq[i].v) begin fails++; $display("FAIL rtype step %0d: got %b expected %b", i, obs_v, tq[i].v); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_load_store();
    tq.delete();
    add_instr(O_LW, 6'd0, 1'b0, 0, 3);
    add_instr(O_SW, 6'd0, 1'b0, 0, 0);
    add_instr(O_SW, 6'd0, 1'b1, 2, 4);
    add_instr(O_LW, 6'd0, 1'b0, 1, 0);
    foreach (tq[i]) begin
      {bus.mem_ready, bus.opcode, bus.funct, bus.zero} = {tq[i].mr, tq[i].op, tq[i].fn, tq[i].z};
      @(negedge clk); tests++;
      if (obs_v !== tq[i].v) begin fails++; $display("FAIL ldst step %0d: got %b expected %b", i, obs_v, tq[i].v); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_branch_jump();
    tq.delete();
    add_instr(O_BEQ, 6'd0, 1'b1, 0, 0);
    add_instr(O_BEQ, 6'd0, 1'b0, 0, 0);
    add_instr(O_BNE, 6'd0, 1'b0, 0, 0);
    add_instr(O_BNE, 6'd0, 1'b1, 1, 0);
    add_instr(O_ADDI, 6'd0, 1'b0, 0, 0);
    add_instr(O_J, 6'd0, 1'b0, 0, 0);
    foreach (tq[i]) begin
      {bus.mem_ready, bus.opcode, bus.funct, bus.zero} = {tq[i].mr, tq[i].op, tq[i].fn, tq[i].z};
      @(negedge clk); tests++;
      if (obs_v !== tq[i].v) begin fails++; $display("FAIL branch step %0d: got %b expected %b", i, obs_v, tq[i].v); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_illegal();
    tq.delete();
    add_instr(6'b111111, 6'd0, 1'b0, 0, 0);
    add_instr(O_R, 6'b000111, 1'b0, 0, 0);
    add_instr(O_ADDI, 6'd0, 1'b0, 0, 0);
    foreach (tq[i]) begin
      {bus.mem_ready, bus.opcode, bus.funct, bus.zero} = {tq[i].mr, tq[i].op, tq[i].fn, tq[i].z};
      @(negedge clk); tests++;
      if (obs_v !== tq[i].v) begin fails++; $display("FAIL illegal step %0d: got %b expected %b", i, obs_v, tq[i].v); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_timeout();
    tq.delete();
    add_instr(O_SW, 6'd0, 1'b0, 0, 15);
    add_instr(O_LW, 6'd0, 1'b0, 0, 20);
    add_instr(O_LW, 6'd0, 1'b0, 0, WAIT_MAX-1);
    add_instr(O_R, 6'b100000, 1'b0, 17, 0);
    foreach (tq[i]) begin
      {bus.mem_ready, bus.opcode, bus.funct, bus.zero} = {tq[i].mr, tq[i].op, tq[i].fn, tq[i].z};
      @(negedge clk); tests++;
      if (obs_v !== tq[i].v) begin fails++; $display("FAIL timeout step %0d: got %b expected %b", i, obs_v, tq[i].v); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_random();
    logic [5:0] ol[8] = '{O_R, O_LW, O_SW, O_BEQ, O_BNE, O_ADDI, O_J, 6'd0};
    logic [5:0] fl[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'd0};
    tq.delete();
    for (int n = 0; n < 40; n++) begin
      ol[7] = 6'($urandom);
      fl[5] = 6'($urandom);
      add_instr(ol[$urandom_range(0, 7)], fl[$urandom_range(0, 5)], rnd(),
                ($urandom_range(0, 7) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 2),
                ($urandom_range(0, 5) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 3));
    end
    foreach (tq[i]) begin
      {bus.mem_ready, bus.opcode, bus.funct, bus.zero} = {tq[i].mr, tq[i].op, tq[i].fn, tq[i].z};
      @(negedge clk); tests++;
      if (obs_v !== tq[i].v) begin fails++; $display("FAIL random step %0d: got %b expected %b", i, obs_v, tq[i].v); end
      @(posedge clk); #1;
    end
  endtask
  initial begin
    test_reset();
    test_rtype();
    test_load_store();
    test_branch_jump();
    test_illegal();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
